// File: rtl/mpu_i2c_target.sv
// mpu_i2c_target: I2C target model of the MPU-6050 register interface.
// It stands in for the real IMU and answers the quadcopter's I2C master.
//
// Ports:
//   clk           50 MHz main clock
//   rst_n         synchronous active-low reset
//   scl           I2C clock from the master
//   sda           I2C data, open-drain (driven 1'b0 or released to 1'bz)
//   sample_valid  one-cycle strobe: new sensor frame on sample_data
//   sample_data   12 sensor bytes for registers 0x3B..0x46 (0x3B in [95:88])
//   reg_wr_en     one-cycle strobe per accepted bus write
//   reg_wr_addr   register address of that write
//   reg_wr_data   value of that write
//   busy          high from START until STOP
//
// Optional build macro: MPU_TARGET_GLITCH_FILTER_EN adds a 3-tap majority
// filter after each synchronizer, rejecting single-clock pulses.
`timescale 1ns/1ps
module mpu_i2c_target #(
  parameter logic [6:0]  DEV_ADDR     = 7'h68,
  parameter int unsigned SDA_HOLD_CYC = 4,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic        sample_valid,
  input  logic [95:0] sample_data,
  output logic        reg_wr_en,
  output logic [6:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_PTR       = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_t;

  typedef logic [127:0][7:0] regfile_t;

  localparam logic [3:0] HOLD_INIT = 4'(SDA_HOLD_CYC);
  // Register 0x6B (PWR_MGMT_1) resets to 0x40, everything else to 0x00.
  localparam regfile_t REGS_RST = regfile_t'(1024'h40 << 11'd856);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic is_read_only(input logic [6:0] a);
    return ((a >= 7'h3B) && (a <= 7'h46)) || (a == 7'h75);
  endfunction

  function automatic regfile_t load_sensor(input regfile_t r, input logic [95:0] d);
    regfile_t res;
    res = r;
    for (int i = 0; i < 12; i++) begin
      res[7'(59 + i)] = d[8*(11-i) +: 8];
    end
    return res;
  endfunction

  // Line conditioning state
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
`ifdef MPU_TARGET_GLITCH_FILTER_EN
  logic scl_t1_q, scl_t1_d, scl_t2_q, scl_t2_d, scl_f_q, scl_f_d;
  logic sda_t1_q, sda_t1_d, sda_t2_q, sda_t2_d, sda_f_q, sda_f_d;
`endif
  logic scl_v, sda_v;

  // Protocol state
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  ptr_q, ptr_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        hold_act_q, hold_act_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  regfile_t    regs_q, regs_d;
  logic        pend_valid_q, pend_valid_d;
  logic [95:0] pend_data_q, pend_data_d;

  logic       scl_rise, scl_fall, start_det, stop_det, in_burst, drive_low;
  logic [7:0] rx_byte;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

  // Synchronize (and optionally filter) scl/sda, keep previous value for edges.
  always_comb begin
    scl_s1_d = scl;
    scl_s2_d = scl_s1_q;
    sda_s1_d = sda;
    sda_s2_d = sda_s1_q;
`ifdef MPU_TARGET_GLITCH_FILTER_EN
    scl_t1_d = scl_s2_q;
    scl_t2_d = scl_t1_q;
    scl_f_d  = maj3(scl_s2_q, scl_t1_q, scl_t2_q);
    sda_t1_d = sda_s2_q;
    sda_t2_d = sda_t1_q;
    sda_f_d  = maj3(sda_s2_q, sda_t1_q, sda_t2_q);
    scl_v    = scl_f_q;
    sda_v    = sda_f_q;
`else
    scl_v    = scl_s2_q;
    sda_v    = sda_s2_q;
`endif
    scl_p_d  = scl_v;
    sda_p_d  = sda_v;
  end

  assign scl_rise  = scl_v & ~scl_p_q;
  assign scl_fall  = ~scl_v & scl_p_q;
  assign start_det = scl_v & scl_p_q & sda_p_q & ~sda_v;
  assign stop_det  = scl_v & scl_p_q & ~sda_p_q & sda_v;
  assign in_burst  = (state_q == ST_RD_DATA) || (state_q == ST_WAIT_STOP);
  assign rx_byte   = {shift_q, sda_v};

  // Level SDA should take once the hold time after an SCL fall has elapsed.
  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      ST_ADDR, ST_PTR, ST_WR_DATA: drive_low = (bit_cnt_q == 4'd8);
      ST_RD_DATA: begin
        if (bit_cnt_q < 4'd8) begin
          drive_low = ~tx_q[3'd7 - bit_cnt_q[2:0]];
        end else begin
          drive_low = 1'b0;
        end
      end
      default: drive_low = 1'b0;
    endcase
  end

  // Next-state logic: sensor loading, bus protocol FSM and SDA hold timer.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    hold_act_d   = hold_act_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;

    // A frame arriving during a read burst is held back so the burst stays
    // coherent; it lands when the burst ends (START or STOP).
    if (start_det || stop_det) begin
      if (pend_valid_q) begin
        regs_d = load_sensor(regs_d, pend_data_q);
      end else begin
        regs_d = regs_d;
      end
      if (sample_valid) begin
        regs_d = load_sensor(regs_d, sample_data);
      end else begin
        regs_d = regs_d;
      end
      pend_valid_d = 1'b0;
    end else if (sample_valid) begin
      if (in_burst) begin
        pend_valid_d = 1'b1;
        pend_data_d  = sample_data;
      end else begin
        regs_d = load_sensor(regs_d, sample_data);
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b1;
      sda_oe_d   = 1'b0;
      hold_act_d = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 4'd0;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      hold_act_d = 1'b0;
    end else begin
      // bit_cnt counts SCL rises within a byte; 8 means the next rise is the ACK slot.
      if (scl_rise) begin
        case (state_q)
          ST_ADDR: begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = rx_byte[6:0];
              bit_cnt_d = bit_cnt_q + 4'd1;
              if ((bit_cnt_q == 4'd7) && (rx_byte[7:1] != DEV_ADDR)) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
              end else begin
                state_d = ST_ADDR;
              end
            end else begin
              bit_cnt_d = 4'd0;
              // shift_q[0] still holds the R/W bit of the address byte.
              if (shift_q[0]) begin
                state_d = ST_RD_DATA;
                tx_d    = (ptr_q == 7'h75) ? WHO_AM_I_VAL : regs_q[ptr_q];
              end else begin
                state_d = ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = rx_byte[6:0];
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                ptr_d = rx_byte[6:0];
              end else begin
                ptr_d = ptr_q;
              end
            end else begin
              bit_cnt_d = 4'd0;
              state_d   = ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = rx_byte[6:0];
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                if (!is_read_only(ptr_q)) begin
                  regs_d[ptr_q] = rx_byte;
                end else begin
                  regs_d = regs_d;
                end
                ptr_d = ptr_q + 7'd1;
              end else begin
                ptr_d = ptr_q;
              end
            end else begin
              bit_cnt_d = 4'd0;
            end
          end
          ST_RD_DATA: begin
            if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (!sda_v) begin
              bit_cnt_d = 4'd0;
              ptr_d     = ptr_q + 7'd1;
              tx_d      = ((ptr_q + 7'd1) == 7'h75) ? WHO_AM_I_VAL : regs_q[ptr_q + 7'd1];
            end else begin
              bit_cnt_d = 4'd0;
              state_d   = ST_WAIT_STOP;
            end
          end
          default: state_d = state_q;
        endcase
      end else begin
        state_d = state_q;
      end

      // SDA only changes a fixed number of clocks after a detected SCL fall.
      if (scl_fall) begin
        hold_cnt_d = HOLD_INIT;
        hold_act_d = 1'b1;
      end else if (hold_act_q) begin
        if (hold_cnt_q <= 4'd1) begin
          hold_act_d = 1'b0;
          sda_oe_d   = drive_low;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end else begin
        hold_act_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_p_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_p_q      <= 1'b1;
`ifdef MPU_TARGET_GLITCH_FILTER_EN
      scl_t1_q     <= 1'b1;
      scl_t2_q     <= 1'b1;
      scl_f_q      <= 1'b1;
      sda_t1_q     <= 1'b1;
      sda_t2_q     <= 1'b1;
      sda_f_q      <= 1'b1;
`endif
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      tx_q         <= 8'd0;
      ptr_q        <= 7'd0;
      hold_cnt_q   <= 4'd0;
      hold_act_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 7'd0;
      wr_data_q    <= 8'd0;
      regs_q       <= REGS_RST;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 96'd0;
    end else begin
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_p_q      <= scl_p_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      sda_p_q      <= sda_p_d;
`ifdef MPU_TARGET_GLITCH_FILTER_EN
      scl_t1_q     <= scl_t1_d;
      scl_t2_q     <= scl_t2_d;
      scl_f_q      <= scl_f_d;
      sda_t1_q     <= sda_t1_d;
      sda_t2_q     <= sda_t2_d;
      sda_f_q      <= sda_f_d;
`endif
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_act_q   <= hold_act_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      regs_q       <= regs_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_mpu_i2c_target.sv
// Self-checking bench for mpu_i2c_target: a bus-level I2C master drives
// transactions; expected register strobes and read bytes go into queues
// and are compared when the target produces them.
`timescale 1ns/1ps
module tb_mpu_i2c_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_oe = 1'b0;
  logic        sample_valid = 1'b0;
  logic [95:0] sample_data = 96'd0;
  wire         sda_bus;
  logic        reg_wr_en;
  logic [6:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          tq = 624;          // quarter SCL period in ns (624 -> ~400 kHz)
  logic        glitch_arm = 1'b0;
  logic [14:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  model[128];
  logic [14:0] e_wr;

  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #10 clk = ~clk;

  mpu_i2c_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl          (scl),
    .sda          (sda_bus),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference register map
  task automatic model_reset();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    model[107] = 8'h40;
  endtask

  task automatic model_sensor(input logic [95:0] d);
    for (int i = 0; i < 12; i++) model[59 + i] = d[8*(11-i) +: 8];
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (!(((a >= 7'h3B) && (a <= 7'h46)) || (a == 7'h75))) model[a] = d;
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    return (a == 7'h75) ? 8'h68 : model[a];
  endfunction

  // Strobe scoreboard: each reg_wr_en pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      check_eq("wr_strobe_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        e_wr = exp_wr_q.pop_front();
        check_eq("wr_strobe", {17'd0, reg_wr_addr, reg_wr_data}, {17'd0, e_wr});
      end
    end
  end

  // Bus-level master primitives; each bit starts and ends with SCL low.
  task automatic send_bit(input logic b);
    #(tq); m_sda_oe = ~b;
    #(tq); scl = 1'b1;
    if (glitch_arm) begin
      glitch_arm = 1'b0;
      #(tq/2);
      @(negedge clk); scl = 1'b0;
      @(negedge clk); scl = 1'b1;
      #(tq);
    end else begin
      #(2*tq);
    end
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #(tq); m_sda_oe = 1'b0;
    #(tq); scl = 1'b1;
    #(tq); b = sda_bus;
    #(tq); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic bv;
    b = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bv);
      b[i] = bv;
    end
    send_bit(nack);
  endtask

  task automatic i2c_start();
    #(tq); m_sda_oe = 1'b0;
    #(tq); scl = 1'b1;
    #(tq); m_sda_oe = 1'b1;
    #(tq); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(tq); m_sda_oe = 1'b1;
    #(tq); scl = 1'b1;
    #(tq); m_sda_oe = 1'b0;
    #(tq);
  endtask

  task automatic pulse_sample(input logic [95:0] d);
    @(negedge clk); sample_data = d; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
  endtask

  // Write n (1 or 2) bytes starting at ptr; dat[15:8] goes first.
  task automatic i2c_write(input logic [6:0] ptr, input int n, input logic [15:0] dat);
    logic ack;
    logic [6:0] a;
    logic [7:0] b;
    a = ptr;
    i2c_start();
    send_byte(8'hD0, ack); check_eq("wr_ack_dev", ack, 0);
    send_byte({1'b0, ptr}, ack); check_eq("wr_ack_ptr", ack, 0);
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? dat[15:8] : dat[7:0];
      exp_wr_q.push_back({a, b});
      model_write(a, b);
      send_byte(b, ack); check_eq("wr_ack_data", ack, 0);
      a = a + 7'd1;
    end
    i2c_stop();
  endtask

  // Set pointer, repeated START, read n bytes (last one NACKed).
  task automatic i2c_read(input logic [6:0] ptr, input int n, input int inj_at, input logic [95:0] inj);
    logic ack;
    logic [7:0] b;
    for (int i = 0; i < n; i++) exp_rd_q.push_back(model_rd(7'(ptr + 7'(i))));
    i2c_start();
    send_byte(8'hD0, ack); check_eq("rd_ack_dev_w", ack, 0);
    send_byte({1'b0, ptr}, ack); check_eq("rd_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hD1, ack); check_eq("rd_ack_dev_r", ack, 0);
    check_eq("busy_in_xfer", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i == inj_at) pulse_sample(inj);
      recv_byte(i == n - 1, b);
      check_eq("rd_byte", b, exp_rd_q.pop_front());
    end
    #(tq/2); check_eq("nack_release", sda_bus, 1);
    i2c_stop();
    check_eq("busy_after_stop", busy, 0);
  endtask

  initial begin
    logic ack;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_en", reg_wr_en, 0);
    check_eq("rst_wr_addr", reg_wr_addr, 0);
    check_eq("rst_wr_data", reg_wr_data, 0);
    check_eq("rst_sda", sda_bus, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // PWR_MGMT_1 reset value, then write 0x00 at 400 kHz and read it back
    i2c_read(7'h6B, 1, -1, 96'd0);
    i2c_write(7'h6B, 1, 16'h0000);
    i2c_read(7'h6B, 1, -1, 96'd0);

    tq = 248;   // remaining traffic at ~1 MHz

    // Sensor frame, then a burst with a newer frame arriving mid-burst
    pulse_sample(96'h0102030405060708090A0B0C);
    model_sensor(96'h0102030405060708090A0B0C);
    i2c_read(7'h3B, 12, 4, 96'hA0A1A2A3A4A5A6A7A8A9AAAB);
    model_sensor(96'hA0A1A2A3A4A5A6A7A8A9AAAB);
    i2c_read(7'h3B, 12, -1, 96'd0);

    // Foreign address: no ACK, busy until STOP, no strobe
    i2c_start();
    send_byte(8'hD2, ack); check_eq("foreign_addr_nack", ack, 1);
    check_eq("foreign_busy", busy, 1);
    send_byte(8'h12, ack); check_eq("foreign_data_nack", ack, 1);
    i2c_stop();
    check_eq("foreign_busy_after_stop", busy, 0);

    // Pointer wrap 0x7F -> 0x00 on write and on read
    i2c_write(7'h7F, 2, 16'h5AA5);
    i2c_read(7'h7F, 2, -1, 96'd0);

    // WHO_AM_I and read-only registers still strobe but keep their value
    i2c_read(7'h75, 1, -1, 96'd0);
    i2c_write(7'h75, 1, 16'h5500);
    i2c_read(7'h75, 1, -1, 96'd0);
    i2c_write(7'h3B, 1, 16'hEE00);
    i2c_read(7'h3B, 1, -1, 96'd0);

`ifdef MPU_TARGET_GLITCH_FILTER_EN
    // One-clock SCL glitch inside the first address bit must be ignored
    glitch_arm = 1'b1;
    i2c_write(7'h10, 1, 16'h3C00);
    i2c_read(7'h10, 1, -1, 96'd0);
`endif

    // Reset while the target is driving a 0 (reg 0x7F = 0x5A, bit7 = 0)
    i2c_start();
    send_byte(8'hD0, ack); check_eq("mid_ack_dev_w", ack, 0);
    send_byte(8'h7F, ack); check_eq("mid_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hD1, ack); check_eq("mid_ack_dev_r", ack, 0);
    #(tq); check_eq("mid_drive_low", sda_bus, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_sda", sda_bus, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_wr_addr", reg_wr_addr, 0);
    scl = 1'b1;
    #(tq); rst_n = 1'b1;
    #(tq);
    model_reset();
    i2c_read(7'h6B, 1, -1, 96'd0);
    i2c_read(7'h3B, 1, -1, 96'd0);

    repeat (10) @(negedge clk);
    check_eq("wr_queue_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_i2c_target.md
Name: mpu_i2c_target

Overview:
- I2C target (slave) model of the MPU-6050 register interface. It is the responder to the quadcopter's I2C master (the `mpu` block).
- Used in simulation and hardware-in-loop builds in place of the real IMU.
- Holds a 128-byte register file: sensor bytes are fed from a stimulus port; bus writes are reported upstream.

Parameters:
- DEV_ADDR, 7'h68, 7-bit target address (write byte 0xD0, read byte 0xD1).
- SDA_HOLD_CYC, 4, clk cycles after a detected SCL fall before SDA output may change (4..15).
- WHO_AM_I_VAL, 8'h68, constant returned at register 0x75.

Ports:
- clk  in  1  main clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- scl  in  1  I2C clock from master
- sda  inout  1  I2C data; open-drain: driven 1'b0 or 1'bz only
- sample_valid  in  1  one-cycle strobe: new sensor frame on sample_data
- sample_data  in  96  12 bytes for 0x3B..0x46; byte 0x3B in [95:88]
- reg_wr_en  out  1  one-cycle strobe per accepted bus write
- reg_wr_addr  out  7  register written
- reg_wr_data  out  8  value written
- busy  out  1  high from START until STOP (or reset)

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0; sda is released (z); state = IDLE; pointer = 0.
  - Register file goes to 0x00, except 0x6B = 0x40.
  - A reset in mid-transfer releases sda in the same cycle.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer. Edges are detected on the synchronized values, giving 2-3 clk latency.
- Bus condition detection:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in any state and override it.
  - START (including a repeated START) -> ADDR, bit counter cleared.
  - STOP -> IDLE.
- SDA output timing: changes only SDA_HOLD_CYC clks after a synchronized SCL fall. The input is sampled on the synchronized SCL rise.
- Bit order: MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If addr[7:1] == DEV_ADDR: ACK. Then R/W=0 -> PTR, R/W=1 -> RD_DATA.
    - Otherwise: no ACK, go to IDLE and ignore the bus until the next START.
  - PTR: shift 8 bits, pointer = byte[6:0]; ACK; -> WR_DATA.
  - WR_DATA: shift 8 bits; ACK.
    - Pulse reg_wr_en one clk with the pointer and data.
    - Update the register unless the address is read-only: 0x3B..0x46 and 0x75 are never written, but the strobe still fires.
    - Pointer increments.
  - RD_DATA:
    - Drive the register[pointer] bit-by-bit; 0x75 returns WHO_AM_I_VAL.
    - On the 9th SCL rise, sample the master ACK. ACK (0) -> pointer++, load the next byte. NACK (1) -> release sda, go to WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- ACK drive: sda held low from the SCL fall after bit 8 until the SCL fall after bit 9 (plus hold).
- Pointer: 7-bit, wraps 0x7F -> 0x00. It persists across transactions, so a read without a preceding PTR continues from the last pointer.
- Sensor coherency:
  - sample_valid outside a read burst loads 0x3B..0x46 in the same clk.
  - During RD_DATA/WAIT_STOP the frame is latched as pending and applied on the cycle STOP/START is detected.
  - A newer strobe overwrites the pending frame.
- busy: set the cycle START is detected, cleared the cycle STOP is detected.
- Simultaneous sample_valid and reg_wr_en: no conflict, since the sensor range is read-only from the bus.

Optional Feature:
- Macro: MPU_TARGET_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a 3-tap majority filter, so a pulse of ≤1 clk on scl or sda is rejected. Adds 2 clk latency; SDA_HOLD_CYC is still measured from the filtered edge.
- Undefined: there is no filter, and a single-cycle glitch is treated as a real edge.

Test Plan:
- Write 0xD0, 0x6B, 0x00 at 400 kHz -> three ACKs, reg_wr_en pulses once with addr 0x6B, data 0x00; a register 0x6B read-back returns 0x00.
- sample_valid with sample_data = 0x0102…0C, then write-ptr 0x3B, repeated START 0xD1, read 12 bytes (ACK ×11, NACK) -> bytes 0x01..0x0C in order; sda released after the NACK.
- sample_valid during the read burst of the previous test with 0xA0..0xAB -> the burst still returns 0x01..0x0C; the next read returns 0xA0..0xAB.
- Address 0xD2 -> no ACK (sda stays z for the whole transfer); busy high until STOP; no reg_wr_en.
- Pointer 0x7F, read 2 bytes -> returns reg 0x7F then reg 0x00; read at 0x75 -> 0x68; write 0x55 to 0x75 -> strobe fires, read still 0x68.
- rst_n low mid-read while driving a 0 -> sda z the next clk, busy = 0, 0x6B reads 0x40; with the macro defined, a 1-clk scl glitch inside a bit is ignored (data intact).
